// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the IF/ID stage and its interrupt front-end.
package if_id_stage_pkg;

  localparam int          W_INSTR_DEF      = 8;
  localparam logic [3:0]  TWO_BYTE_OPC_DEF = 4'd12;
  localparam logic [7:0]  NOP_INSTR_DEF    = 8'h00;

  // Opcode field occupies the upper nibble of the instruction byte
  localparam int          OPC_W            = 4;
  localparam int          OPC_MSB          = 7;
  localparam int          OPC_LSB          = 4;

  // Fetch assembly state: expecting an opcode byte or an immediate byte
  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

endpackage

// File: rtl/if_id_stage_intr_sync.sv
// External interrupt front-end: two-flop synchroniser, rising-edge detect
// and a pending latch in which a new edge wins over a same-cycle clear.
module if_id_stage_intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic intr_pin_i,
  input  logic int_clr_i,
  output logic pending_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise      = sync2_q & ~prev_q;
  assign pending_d = rise | (pending_q & ~int_clr_i);
  assign pending_o = pending_q;

  // Synchronise the raw pin, remember last level, and latch edges into pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= intr_pin_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: assembles opcode+immediate instructions, holds on
// stall, bubbles on flush, and gates the pending interrupt to safe boundaries.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int                  W_INSTR      = W_INSTR_DEF,
  parameter logic [OPC_W-1:0]    TWO_BYTE_OPC = TWO_BYTE_OPC_DEF,
  parameter logic [W_INSTR-1:0]  NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_INSTR-1:0] instr_in,
  input  logic [W_INSTR-1:0] pc_in,
  input  logic               sf1_in,
  input  logic               stall,
  input  logic               flush,
  input  logic               intr_pin,
  input  logic               int_clr,
  input  logic               int_active,
  output logic [W_INSTR-1:0] IR,
  output logic [W_INSTR-1:0] imm,
  output logic               imm_valid,
  output logic               ir_valid,
  output logic [W_INSTR-1:0] pc_out,
  output logic               reg_sf1,
  output logic               intr
);

  state_t              state_q;
  logic [W_INSTR-1:0]  ir_q;
  logic [W_INSTR-1:0]  imm_q;
  logic                imm_valid_q;
  logic                ir_valid_q;
  logic [W_INSTR-1:0]  pc_q;
  logic                sf1_q;
  logic                intr_q;
  logic                intr_d;
  logic                pending;
  logic                two_byte;

  if_id_stage_intr_sync u_intr_sync (
    .clk        (clk),
    .rst        (rst),
    .intr_pin_i (intr_pin),
    .int_clr_i  (int_clr),
    .pending_o  (pending)
  );

  // Interrupt-injected slots carry a PC, never an immediate, even if the
  // byte happens to look like a two-byte opcode.
  assign two_byte = (instr_in[W_INSTR-1 -: OPC_W] == TWO_BYTE_OPC) && !sf1_in;

  // Only offer the interrupt between instructions and outside an ISR
  assign intr_d = pending & ~int_active & (state_q == S_OP);

  // Fetch FSM and IF/ID registers; flush beats stall, intr keeps updating under stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_OP;
      ir_q        <= NOP_INSTR;
      imm_q       <= '0;
      imm_valid_q <= 1'b0;
      ir_valid_q  <= 1'b0;
      pc_q        <= '0;
      sf1_q       <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      intr_q <= intr_d;
      if (flush) begin
        ir_q        <= NOP_INSTR;
        ir_valid_q  <= 1'b0;
        imm_valid_q <= 1'b0;
        sf1_q       <= 1'b0;
        state_q     <= S_OP;
      end else if (!stall) begin
        case (state_q)
          S_OP: begin
            ir_q        <= instr_in;
            pc_q        <= pc_in;
            sf1_q       <= sf1_in;
            imm_valid_q <= 1'b0;
            if (two_byte) begin
              ir_valid_q <= 1'b0;
              state_q    <= S_IMM;
            end else begin
              ir_valid_q <= 1'b1;
              state_q    <= S_OP;
            end
          end
          S_IMM: begin
            imm_q       <= instr_in;
            imm_valid_q <= 1'b1;
            ir_valid_q  <= 1'b1;
            state_q     <= S_OP;
          end
          default: state_q <= S_OP;
        endcase
      end
    end
  end

  assign IR        = ir_q;
  assign imm       = imm_q;
  assign imm_valid = imm_valid_q;
  assign ir_valid  = ir_valid_q;
  assign pc_out    = pc_q;
  assign reg_sf1   = sf1_q;
  assign intr      = intr_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: instruction assembly, stall/flush and
// interrupt presentation, with hand-computed expected values.
module tb_if_id_stage;

  logic       clk;
  logic       rst;
  logic [7:0] instr_in;
  logic [7:0] pc_in;
  logic       sf1_in;
  logic       stall;
  logic       flush;
  logic       intr_pin;
  logic       int_clr;
  logic       int_active;
  logic [7:0] IR;
  logic [7:0] imm;
  logic       imm_valid;
  logic       ir_valid;
  logic [7:0] pc_out;
  logic       reg_sf1;
  logic       intr;

  int n_chk  = 0;
  int n_pass = 0;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .pc_in      (pc_in),
    .sf1_in     (sf1_in),
    .stall      (stall),
    .flush      (flush),
    .intr_pin   (intr_pin),
    .int_clr    (int_clr),
    .int_active (int_active),
    .IR         (IR),
    .imm        (imm),
    .imm_valid  (imm_valid),
    .ir_valid   (ir_valid),
    .pc_out     (pc_out),
    .reg_sf1    (reg_sf1),
    .intr       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_IR"},   int'(IR),        'h00);
    chk({tag, "_imm"},  int'(imm),       'h00);
    chk({tag, "_immv"}, int'(imm_valid), 0);
    chk({tag, "_irv"},  int'(ir_valid),  0);
    chk({tag, "_pc"},   int'(pc_out),    'h00);
    chk({tag, "_sf1"},  int'(reg_sf1),   0);
    chk({tag, "_intr"}, int'(intr),      0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; instr_in = 8'h00; pc_in = 8'h00; sf1_in = 1'b0;
    stall = 1'b0; flush = 1'b0; intr_pin = 1'b0; int_clr = 1'b0; int_active = 1'b0;
    repeat (3) tick();
    chk_reset("rst0");
    rst = 1'b1;

    // Single-byte instruction
    instr_in = 8'h5A; pc_in = 8'h10; tick();
    chk("sb_IR", int'(IR), 'h5A);
    chk("sb_irv", int'(ir_valid), 1);
    chk("sb_immv", int'(imm_valid), 0);
    chk("sb_pc", int'(pc_out), 'h10);

    // Two-byte instruction
    instr_in = 8'hC4; pc_in = 8'h11; tick();
    chk("tb1_irv", int'(ir_valid), 0);
    instr_in = 8'h37; pc_in = 8'h12; tick();
    chk("tb2_IR", int'(IR), 'hC4);
    chk("tb2_imm", int'(imm), 'h37);
    chk("tb2_immv", int'(imm_valid), 1);
    chk("tb2_irv", int'(ir_valid), 1);
    chk("tb2_pc", int'(pc_out), 'h11);

    // Stall three cycles in S_IMM with toggling input
    instr_in = 8'hC1; pc_in = 8'h20; tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = (i % 2 == 0) ? 8'h99 : 8'h66;
      tick();
      chk("stl_IR", int'(IR), 'hC1);
      chk("stl_irv", int'(ir_valid), 0);
      chk("stl_imm", int'(imm), 'h37);
    end
    stall = 1'b0; instr_in = 8'h42; tick();
    chk("stlr_IR", int'(IR), 'hC1);
    chk("stlr_imm", int'(imm), 'h42);
    chk("stlr_irv", int'(ir_valid), 1);

    // Flush together with stall in S_IMM
    instr_in = 8'hC2; tick();
    stall = 1'b1; flush = 1'b1; tick();
    chk("fl_IR", int'(IR), 'h00);
    chk("fl_irv", int'(ir_valid), 0);
    chk("fl_immv", int'(imm_valid), 0);
    stall = 1'b0; flush = 1'b0; instr_in = 8'h5B; tick();
    chk("fl_next_IR", int'(IR), 'h5B);
    chk("fl_next_irv", int'(ir_valid), 1);

    // Injected slot with two-byte-looking opcode is single-byte
    instr_in = 8'hC3; sf1_in = 1'b1; tick();
    chk("sf1_irv", int'(ir_valid), 1);
    chk("sf1_reg", int'(reg_sf1), 1);
    sf1_in = 1'b0;

    // Interrupt pulse during S_IMM
    instr_in = 8'hC5; tick();
    intr_pin = 1'b1; instr_in = 8'h77; tick();
    chk("ip_k0_intr", int'(intr), 0);
    chk("ip_k0_imm", int'(imm), 'h77);
    instr_in = 8'h00; tick();
    intr_pin = 1'b0;
    chk("ip_k1_intr", int'(intr), 0);
    tick();
    chk("ip_k2_intr", int'(intr), 0);
    tick();
    chk("ip_k3_intr", int'(intr), 1);

    // Plain acknowledge clears the request
    int_clr = 1'b1; tick();
    int_clr = 1'b0; tick();
    chk("clr_intr", int'(intr), 0);

    // Re-arm pending, then a new edge coincides with a clear
    intr_pin = 1'b1; tick();
    intr_pin = 1'b0; tick();
    tick();
    tick();
    chk("rearm_intr", int'(intr), 1);
    intr_pin = 1'b1; tick();
    tick();
    int_clr = 1'b1; tick();
    int_clr = 1'b0; tick();
    chk("setclr_intr", int'(intr), 1);
    intr_pin = 1'b0;

    // Edge during ISR is latched and shown when ISR ends
    int_clr = 1'b1; tick();
    int_clr = 1'b0; tick();
    tick();
    tick();
    int_active = 1'b1; intr_pin = 1'b1;
    repeat (5) tick();
    chk("isr_mask_intr", int'(intr), 0);
    int_active = 1'b0; tick();
    chk("isr_end_intr", int'(intr), 1);
    intr_pin = 1'b0;

    // Pending request hidden while mid two-byte fetch
    instr_in = 8'hC6; tick();
    instr_in = 8'h11; tick();
    chk("imm_mask_intr", int'(intr), 0);
    chk("imm_mask_imm", int'(imm), 'h11);
    tick();
    chk("imm_after_intr", int'(intr), 1);

    // Asynchronous reset mid two-byte fetch
    instr_in = 8'hC7; tick();
    rst = 1'b0;
    #2;
    chk_reset("rst1");
    tick();
    rst = 1'b1; instr_in = 8'h5C; pc_in = 8'h30; tick();
    chk("rst1_next_IR", int'(IR), 'h5C);
    chk("rst1_next_irv", int'(ir_valid), 1);
    chk("rst1_next_pc", int'(pc_out), 'h30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
